// File: rtl/grid_pkg.sv
// Shared types, colour constants and tile geometry for digit_grid_renderer.
package grid_pkg;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb_t;

    localparam rgb_t COL_WHITE = '{r: 3'd7, g: 3'd7, b: 2'd3};
    localparam rgb_t COL_SEL   = '{r: 3'd7, g: 3'd0, b: 2'd0};
    localparam rgb_t COL_BLACK = '{r: 3'd0, g: 3'd0, b: 2'd0};

    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    typedef enum logic {
        BLINK_ON  = 1'b0,
        BLINK_OFF = 1'b1
    } blink_state_t;

    // Columns are spaced evenly, with an extra gap after every completed group.
    function automatic int col_left(input int c, input int x0, input int tile_w,
                                    input int gap_x, input int group, input int group_gap);
        return x0 + c * (tile_w + gap_x) + (c / group) * group_gap;
    endfunction

endpackage

// File: rtl/seg_mask.sv
// Seven-segment pixel mask: decides whether an offset inside a tile is lit for a digit.
module seg_mask #(
    parameter int TILE_W = 80,
    parameter int TILE_H = 140,
    parameter int SEG_T  = 12
) (
    input  logic [3:0] digit,
    input  logic [9:0] x_off,
    input  logic [9:0] y_off,
    output logic       pixel_on
);

    localparam int HALF = TILE_H / 2;
    localparam int G_LO = HALF - SEG_T / 2;
    localparam int G_HI = HALF + SEG_T / 2;

    logic [6:0] segs;  // {a, b, c, d, e, f, g}
    logic       left_col, right_col, mid_span, upper;
    logic       row_a, row_g, row_d;

    always_comb begin
        segs = 7'b0000000;
        unique case (digit)
            4'd0:    segs = 7'b1111110;
            4'd1:    segs = 7'b0110000;
            4'd2:    segs = 7'b1101101;
            4'd3:    segs = 7'b1111001;
            4'd4:    segs = 7'b0110011;
            4'd5:    segs = 7'b1011011;
            4'd6:    segs = 7'b1011111;
            4'd7:    segs = 7'b1110000;
            4'd8:    segs = 7'b1111111;
            4'd9:    segs = 7'b1111011;
            default: segs = 7'b0000000;
        endcase
    end

    assign left_col  = int'(x_off) < SEG_T;
    assign right_col = int'(x_off) >= TILE_W - SEG_T;
    assign mid_span  = !left_col && !right_col;
    assign upper     = int'(y_off) < HALF;
    assign row_a     = int'(y_off) < SEG_T;
    assign row_g     = int'(y_off) >= G_LO && int'(y_off) < G_HI;
    assign row_d     = int'(y_off) >= TILE_H - SEG_T;

    assign pixel_on = (segs[6] && mid_span && row_a)
                   || (segs[5] && right_col && upper)
                   || (segs[4] && right_col && !upper)
                   || (segs[3] && mid_span && row_d)
                   || (segs[2] && left_col && !upper)
                   || (segs[1] && left_col && upper)
                   || (segs[0] && mid_span && row_g);

endmodule

// File: rtl/digit_grid_renderer.sv
// Two-stage pipelined renderer of a ROWS x COLS seven-segment digit grid.
// Define GRID_BLINK_EN to make selected groups blink; otherwise they stay solid red.
module digit_grid_renderer
    import grid_pkg::*;
#(
    parameter int ROWS         = 2,
    parameter int COLS         = 6,
    parameter int GROUP        = 3,
    parameter int X0           = 20,
    parameter int Y0           = 20,
    parameter int TILE_W       = 80,
    parameter int TILE_H       = 140,
    parameter int GAP_X        = 20,
    parameter int GAP_Y        = 40,
    parameter int GROUP_GAP    = 20,
    parameter int SEG_T        = 12,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [9:0]                     sx,
    input  logic [9:0]                     sy,
    input  logic                           de,
    input  logic                           frame_start,
    input  logic [4*ROWS*COLS-1:0]         numbers_concat,
    input  logic [ROWS*COLS/GROUP-1:0]     sel,
    output logic [2:0]                     vga_r,
    output logic [2:0]                     vga_g,
    output logic [1:0]                     vga_b
);

    localparam int NDIG  = ROWS * COLS;
    localparam int NGRP  = NDIG / GROUP;
    localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;

    if (COLS % GROUP != 0) begin : g_bad_group
        $error("GROUP must divide COLS");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("BLINK_FRAMES must be at least 1");
    end

    logic [4*NDIG-1:0] num_q;
    logic [NGRP-1:0]   sel_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_q <= {NDIG{DIGIT_BLANK}};
            sel_q <= '0;
        end else if (frame_start) begin
            num_q <= numbers_concat;
            sel_q <= sel;
        end
    end

    // Stage 1: locate the tile under (sx, sy) and fetch its digit.
    logic       col_hit, row_hit;
    int         col_idx, row_idx, dig_idx;
    logic [9:0] x_off_d, y_off_d;

    always_comb begin
        col_hit = 1'b0;
        col_idx = 0;
        x_off_d = '0;
        for (int c = 0; c < COLS; c++) begin
            if (int'(sx) >= col_left(c, X0, TILE_W, GAP_X, GROUP, GROUP_GAP) &&
                int'(sx) <  col_left(c, X0, TILE_W, GAP_X, GROUP, GROUP_GAP) + TILE_W) begin
                col_hit = 1'b1;
                col_idx = c;
                x_off_d = 10'(int'(sx) - col_left(c, X0, TILE_W, GAP_X, GROUP, GROUP_GAP));
            end
        end
        row_hit = 1'b0;
        row_idx = 0;
        y_off_d = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (int'(sy) >= Y0 + r * (TILE_H + GAP_Y) &&
                int'(sy) <  Y0 + r * (TILE_H + GAP_Y) + TILE_H) begin
                row_hit = 1'b1;
                row_idx = r;
                y_off_d = 10'(int'(sy) - (Y0 + r * (TILE_H + GAP_Y)));
            end
        end
        dig_idx = row_idx * COLS + col_idx;
    end

    logic             hit_q, de_q;
    logic [3:0]       digit_q;
    logic [9:0]       x_off_q, y_off_q;
    logic [GRP_W-1:0] grp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q   <= 1'b0;
            de_q    <= 1'b0;
            digit_q <= DIGIT_BLANK;
            x_off_q <= '0;
            y_off_q <= '0;
            grp_q   <= '0;
        end else begin
            hit_q   <= col_hit && row_hit;
            de_q    <= de;
            digit_q <= num_q[(NDIG - 1 - dig_idx) * 4 +: 4];
            x_off_q <= x_off_d;
            y_off_q <= y_off_d;
            grp_q   <= GRP_W'(dig_idx / GROUP);
        end
    end

    logic blink_on;

`ifdef GRID_BLINK_EN
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    blink_state_t     state_q, state_d;
    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BLINK_ON;
            blink_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        blink_cnt_d = blink_cnt_q;
        if (frame_start) begin
            if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                state_d     = (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    assign blink_on = (state_q == BLINK_ON);
`else
    assign blink_on = 1'b1;
`endif

    // Stage 2: segment mask and colour selection.
    logic pixel_on;
    rgb_t rgb_d, rgb_q;

    seg_mask #(
        .TILE_W (TILE_W),
        .TILE_H (TILE_H),
        .SEG_T  (SEG_T)
    ) u_seg_mask (
        .digit    (digit_q),
        .x_off    (x_off_q),
        .y_off    (y_off_q),
        .pixel_on (pixel_on)
    );

    always_comb begin
        rgb_d = COL_BLACK;
        if (de_q && hit_q && pixel_on) begin
            rgb_d = (sel_q[grp_q] && blink_on) ? COL_SEL : COL_WHITE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rgb_q <= COL_BLACK;
        else     rgb_q <= rgb_d;
    end

    assign vga_r = rgb_q.r;
    assign vga_g = rgb_q.g;
    assign vga_b = rgb_q.b;

endmodule

// File: tb/tb_digit_grid_renderer.sv
// Directed self-checking bench for digit_grid_renderer (default geometry).
module tb_digit_grid_renderer;

    localparam logic [7:0] WHITE = 8'hFF;
    localparam logic [7:0] RED   = 8'hE0;
    localparam logic [7:0] BLACK = 8'h00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  sx = '0, sy = '0;
    logic        de = 1'b0;
    logic        frame_start = 1'b0;
    logic [47:0] numbers_concat = '0;
    logic [3:0]  sel = '0;
    logic [2:0]  vga_r, vga_g;
    logic [1:0]  vga_b;

    int checks = 0;
    int errors = 0;
    int nf     = 0;

    digit_grid_renderer dut (
        .clk            (clk),
        .rst            (rst),
        .sx             (sx),
        .sy             (sy),
        .de             (de),
        .frame_start    (frame_start),
        .numbers_concat (numbers_concat),
        .sel            (sel),
        .vga_r          (vga_r),
        .vga_g          (vga_g),
        .vga_b          (vga_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int x, input int y, input logic [7:0] exp, input string tag);
        @(negedge clk);
        sx = 10'(x);
        sy = 10'(y);
        de = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check(tag, {vga_r, vga_g, vga_b}, exp);
    endtask

    task automatic frame(input logic [47:0] nums, input logic [3:0] s);
        @(negedge clk);
        numbers_concat = nums;
        sel = s;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        nf++;
    endtask

    function automatic logic [7:0] sel_colour();
`ifdef GRID_BLINK_EN
        return ((nf / 30) % 2 == 0) ? RED : WHITE;
`else
        return RED;
`endif
    endfunction

    logic [7:0] pat = 8'b1011_0010;
    logic [7:0] exp_de;

    initial begin
        #12;
        check("reset_vga", {vga_r, vga_g, vga_b}, BLACK);
        @(negedge clk);
        rst = 1'b0;

        sample(60, 22, BLACK, "blank_before_frame");

        frame(48'h0123_4567_89AB, 4'b0000);
        sample(60, 22, WHITE, "d0_seg_a");
        sample(60, 50, BLACK, "d0_interior");
        sample(480, 202, BLACK, "tile10_blank");
        sample(580, 202, BLACK, "tile11_blank");
        sample(340, 210, WHITE, "col3_left_edge");
        sample(339, 210, BLACK, "col3_gap");
        sample(619, 120, WHITE, "col5_right_edge");
        sample(620, 120, BLACK, "col5_outside");
        sample(60, 159, WHITE, "row0_bottom");
        sample(60, 160, BLACK, "row0_below");
        sample(60, 339, WHITE, "row1_bottom");
        sample(60, 340, BLACK, "row1_below");

        frame(48'h0123_4567_89AB, 4'b0010);
        sample(380, 22, RED, "grp1_d3_red");
        sample(580, 22, RED, "grp1_d5_red");
        sample(60, 22, WHITE, "grp0_white");
        sample(60, 339, WHITE, "grp2_white");

        while (nf < 30) frame(48'h0123_4567_89AB, 4'b0010);
        sample(380, 22, sel_colour(), "blink_after_30");
        while (nf < 60) frame(48'h0123_4567_89AB, 4'b0010);
        sample(380, 22, sel_colour(), "blink_after_60");

        // de pattern must reappear on the output two cycles later
        @(negedge clk);
        sx = 10'd60;
        sy = 10'd22;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            de = (k < 8) ? pat[k] : 1'b0;
            @(posedge clk);
            #1;
            if (k >= 1) begin
                exp_de = pat[k-1] ? WHITE : BLACK;
                check("de_align", {vga_r, vga_g, vga_b}, exp_de);
            end
        end

        // Digit 0 becomes 1 (no segment a) without a frame_start
        @(negedge clk);
        numbers_concat = 48'h1123_4567_89AB;
        sample(60, 22, WHITE, "no_tear_midframe");

        @(negedge clk);
        sx = 10'd60;
        sy = 10'd22;
        de = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        nf++;
        @(posedge clk);
        #1;
        check("inflight_old", {vga_r, vga_g, vga_b}, WHITE);
        @(posedge clk);
        #1;
        check("new_value_visible", {vga_r, vga_g, vga_b}, BLACK);

        sample(380, 22, sel_colour(), "pre_reset");
        #2;
        rst = 1'b1;
        #1;
        check("reset_async", {vga_r, vga_g, vga_b}, BLACK);
        @(negedge clk);
        rst = 1'b0;
        nf = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("blank_after_reset", {vga_r, vga_g, vga_b}, BLACK);
        end
        frame(48'h0123_4567_89AB, 4'b0010);
        sample(380, 22, RED, "after_reset_frame");
        sample(60, 22, WHITE, "after_reset_white");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
